// File: rtl/div_pkg.sv
// Shared definitions for the eBPF divider arbiter: FSM encoding and ALU32 operand mask.
package div_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  // ALU32 ops see only the low word of each 64-bit register.
  localparam logic [63:0] ALU32_MASK = 64'h0000_0000_FFFF_FFFF;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester, response and divider buses of div_arbiter; slave is the arbiter side.
interface div_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_W       = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]            req_is_mod;
  logic [NUM_REQ-1:0]            req_is_32;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_div0;

  logic                          div_stb;
  logic [DATA_WIDTH-1:0]         div_dividend;
  logic [DATA_WIDTH-1:0]         div_divisor;
  logic [DATA_WIDTH-1:0]         div_quotient;
  logic [DATA_WIDTH-1:0]         div_remainder;
  logic                          div_ack;
  logic                          div_err;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_is_mod, req_is_32,
    input  rsp_ready,
    input  div_quotient, div_remainder, div_ack, div_err,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_div0,
    output div_stb, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_is_mod, req_is_32,
    output rsp_ready,
    output div_quotient, div_remainder, div_ack, div_err,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_div0,
    input  div_stb, div_dividend, div_divisor
  );

endinterface

// File: rtl/div_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    // NOTE: every output and temporary gets a default before the loop so no path leaves
    // a value unassigned; otherwise synthesis infers a latch to hold the old value.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NUM_REQ eBPF ALU requesters with DIV/MOD, ALU32/64
// and divide-by-zero semantics; one operation in flight, tagged valid/ready response.
module div_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input logic         clk,
  input logic         reset_n,
  div_arbiter_if.slave bus
);

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic                  rsp_div0_q;
  logic                  div_stb_q;

  logic [DATA_WIDTH-1:0] op_dividend;
  logic [DATA_WIDTH-1:0] op_divisor;
  logic                  op_is_mod;
  logic                  op_is_32;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       next_ptr;
  logic                  accept;

  logic [DATA_WIDTH-1:0] dividend_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] divisor_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] sel_dividend;
  logic [DATA_WIDTH-1:0] sel_divisor;
  logic                  sel_is_mod;
  logic                  sel_is_32;
  logic [DATA_WIDTH-1:0] div_result;

  function automatic logic [DATA_WIDTH-1:0] mask32(input logic [DATA_WIDTH-1:0] op,
                                                   input logic                  is_32);
    return is_32 ? (op & ALU32_MASK[DATA_WIDTH-1:0]) : op;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dividend_arr[i] = bus.req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
    assign divisor_arr[i]  = bus.req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant is offered only while idle and out of reset, so req_ready is one-hot or zero.
  assign accept        = reset_n && (state == IDLE) && (|grant);
  assign bus.req_ready = accept ? grant : '0;
  assign next_ptr      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_is_mod   = bus.req_is_mod[grant_idx];
    sel_is_32    = bus.req_is_32[grant_idx];
    sel_dividend = mask32(dividend_arr[grant_idx], sel_is_32);
    sel_divisor  = mask32(divisor_arr[grant_idx], sel_is_32);
  end

  always_comb begin
    div_result = mask32(op_is_mod ? bus.div_remainder : bus.div_quotient, op_is_32);
  end

  // NOTE: operand latches carry no reset; they are only read after a fresh accept has
  // loaded them, so a reset term would add muxing for no functional gain.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_dividend <= sel_dividend;
      op_divisor  <= sel_divisor;
      op_is_mod   <= sel_is_mod;
      op_is_32    <= sel_is_32;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_div0_q  <= 1'b0;
      div_stb_q   <= 1'b0;
    end else begin
      div_stb_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id_q <= grant_idx;
            rr_ptr   <= next_ptr;
            if (sel_divisor == '0) begin
              // eBPF divide-by-zero: DIV yields 0, MOD leaves the dividend; divider untouched.
              rsp_valid_q <= 1'b1;
              rsp_div0_q  <= 1'b1;
              rsp_data_q  <= sel_is_mod ? sel_dividend : '0;
              state       <= RESP;
            end else begin
              div_stb_q <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.div_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= div_result;
            rsp_div0_q  <= bus.div_err;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_div0     = rsp_div0_q;
  assign bus.div_stb      = div_stb_q;
  assign bus.div_dividend = op_dividend;
  assign bus.div_divisor  = op_divisor;

endmodule
